// File: rtl/mips_cpu_mem_access.sv
// Memory-access stage: one Avalon-MM read or write per accepted request, extended load data back.
// Latency: accept at edge 0, strobe in cycle 1, resp_valid in cycle 2, plus one cycle per waitrequest cycle.
// Backpressure: req_ready only in IDLE; bus strobes and payload are held while avm_waitrequest is high.
module mips_cpu_mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] eff_addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              addr_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic       legal;
        logic       store;
        logic       sgn;
        logic [1:0] size;
    } dec_t;

    // Opcode decode: access size, direction and load extension kind.
    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d = '0;
        case (op)
            6'h20: d = '{legal: 1'b1, store: 1'b0, sgn: 1'b1, size: SZ_BYTE};  // lb
            6'h21: d = '{legal: 1'b1, store: 1'b0, sgn: 1'b1, size: SZ_HALF};  // lh
            6'h23: d = '{legal: 1'b1, store: 1'b0, sgn: 1'b0, size: SZ_WORD};  // lw
            6'h24: d = '{legal: 1'b1, store: 1'b0, sgn: 1'b0, size: SZ_BYTE};  // lbu
            6'h25: d = '{legal: 1'b1, store: 1'b0, sgn: 1'b0, size: SZ_HALF};  // lhu
            6'h28: d = '{legal: 1'b1, store: 1'b1, sgn: 1'b0, size: SZ_BYTE};  // sb
            6'h29: d = '{legal: 1'b1, store: 1'b1, sgn: 1'b0, size: SZ_HALF};  // sh
            6'h2B: d = '{legal: 1'b1, store: 1'b1, sgn: 1'b0, size: SZ_WORD};  // sw
            default: d = '0;
        endcase
        return d;
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              addr_error_q, addr_error_d;
    logic [ADDR_W-1:0] avm_address_q, avm_address_d;
    logic              avm_read_q, avm_read_d;
    logic              avm_write_q, avm_write_d;
    logic [3:0]        avm_be_q, avm_be_d;
    logic [DATA_W-1:0] avm_wdata_q, avm_wdata_d;

    dec_t              dec;
    logic              aligned;
    logic [3:0]        be_new;
    logic [DATA_W-1:0] wdata_new;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [DATA_W-1:0] rd_ext;

    // Request decode: alignment, byte lanes and lane-replicated store data for the incoming request.
    always_comb begin
        dec       = decode(opcode);
        aligned   = 1'b1;
        be_new    = 4'b1111;
        wdata_new = store_data;
        case (dec.size)
            SZ_BYTE: begin
                be_new    = 4'b0001 << eff_addr[1:0];
                wdata_new = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                aligned   = ~eff_addr[0];
                be_new    = eff_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data[15:0]}};
            end
            default: begin
                aligned   = (eff_addr[1:0] == 2'b00);
                be_new    = 4'b1111;
                wdata_new = store_data;
            end
        endcase
    end

    // Load extraction: pick the addressed lane from read data and sign/zero extend it.
    always_comb begin
        rd_byte = 8'h00;
        case (addr_lo_q)
            2'd0:    rd_byte = avm_readdata[7:0];
            2'd1:    rd_byte = avm_readdata[15:8];
            2'd2:    rd_byte = avm_readdata[23:16];
            default: rd_byte = avm_readdata[31:24];
        endcase
        rd_half = addr_lo_q[1] ? avm_readdata[31:16] : avm_readdata[15:0];
        case (size_q)
            SZ_BYTE: rd_ext = {{24{sgn_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: rd_ext = {{16{sgn_q & rd_half[15]}}, rd_half};
            default: rd_ext = avm_readdata;
        endcase
    end

    // Next-state logic: IDLE accepts, BUS waits out waitrequest, RESP pulses for one cycle.
    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        sgn_d         = sgn_q;
        addr_lo_d     = addr_lo_q;
        load_data_d   = load_data_q;
        addr_error_d  = addr_error_q;
        avm_address_d = avm_address_q;
        avm_read_d    = avm_read_q;
        avm_write_d   = avm_write_q;
        avm_be_d      = avm_be_q;
        avm_wdata_d   = avm_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d    = dec.size;
                    sgn_d     = dec.sgn;
                    addr_lo_d = eff_addr[1:0];
                    if (dec.legal && aligned) begin
                        state_d       = ST_BUS;
                        avm_read_d    = ~dec.store;
                        avm_write_d   = dec.store;
                        avm_address_d = {eff_addr[ADDR_W-1:2], 2'b00};
                        avm_be_d      = be_new;
                        avm_wdata_d   = wdata_new;
                    end else begin
                        // Rejected requests never touch the bus.
                        state_d      = ST_RESP;
                        addr_error_d = 1'b1;
                        load_data_d  = '0;
                    end
                end
            end
            ST_BUS: begin
                if (!avm_waitrequest) begin
                    state_d      = ST_RESP;
                    avm_read_d   = 1'b0;
                    avm_write_d  = 1'b0;
                    addr_error_d = 1'b0;
                    if (avm_read_q) begin
                        load_data_d = rd_ext;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            size_q        <= SZ_BYTE;
            sgn_q         <= 1'b0;
            addr_lo_q     <= 2'b00;
            load_data_q   <= '0;
            addr_error_q  <= 1'b0;
            avm_address_q <= '0;
            avm_read_q    <= 1'b0;
            avm_write_q   <= 1'b0;
            avm_be_q      <= 4'b0000;
            avm_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            sgn_q         <= sgn_d;
            addr_lo_q     <= addr_lo_d;
            load_data_q   <= load_data_d;
            addr_error_q  <= addr_error_d;
            avm_address_q <= avm_address_d;
            avm_read_q    <= avm_read_d;
            avm_write_q   <= avm_write_d;
            avm_be_q      <= avm_be_d;
            avm_wdata_q   <= avm_wdata_d;
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign resp_valid     = (state_q == ST_RESP);
    assign load_data      = load_data_q;
    assign addr_error     = addr_error_q;
    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_byteenable = avm_be_q;
    assign avm_writedata  = avm_wdata_q;

endmodule

// File: tb/tb_mips_cpu_mem_access.sv
module tb_mips_cpu_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  opcode = 6'h00;
    logic [31:0] eff_addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        addr_error;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_waitrequest = 1'b0;

    mips_cpu_mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .reset           (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .opcode          (opcode),
        .eff_addr        (eff_addr),
        .store_data      (store_data),
        .resp_valid      (resp_valid),
        .load_data       (load_data),
        .addr_error      (addr_error),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chk_data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        wr;
        int          waits;
        logic [31:0] rdata;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    n_xfer = 0;
    int    exp_xfer = 0;
    int    stall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus slave: checks every strobe cycle against the expected transfer, inserts wait states.
    always @(negedge clk) begin
        if (rst) begin
            stall = 0;
            avm_waitrequest = 1'b0;
        end else if (avm_read || avm_write) begin
            chk("rw_exclusive", {31'b0, avm_read & avm_write}, 32'h0);
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", 32'h1, 32'h0);
                avm_waitrequest = 1'b0;
            end else begin
                chk("bus_addr", avm_address, bus_q[0].addr);
                chk("bus_be", {28'b0, avm_byteenable}, {28'b0, bus_q[0].be});
                chk("bus_dir", {31'b0, avm_write}, {31'b0, bus_q[0].wr});
                if (bus_q[0].wr) chk("bus_wdata", avm_writedata, bus_q[0].wd);
                avm_readdata = bus_q[0].rdata;
                if (stall < bus_q[0].waits) begin
                    avm_waitrequest = 1'b1;
                    stall++;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall = 0;
                    void'(bus_q.pop_front());
                    n_xfer++;
                end
            end
        end else begin
            avm_waitrequest = 1'b0;
        end
    end

    // Response monitor: pops the scoreboard whenever the stage reports completion.
    always @(negedge clk) begin
        resp_t r;
        if (!rst && resp_valid) begin
            if (resp_q.size() == 0) begin
                chk("resp_unexpected", 32'h1, 32'h0);
            end else begin
                r = resp_q.pop_front();
                chk("resp_latency", cyc, r.cyc);
                chk("addr_error", {31'b0, addr_error}, {31'b0, r.err});
                if (r.chk_data) chk("load_data", load_data, r.data);
            end
        end
    end

    // Drive one request, wait for acceptance, and record expected bus and response activity.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input int waits, input logic [31:0] rdata, input logic [31:0] exp_data,
                         input bit chk_data, input logic exp_err, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic exp_wr, input bit hold);
        int n;
        resp_t r;
        bus_t  b;
        n = 0;
        opcode     = op;
        eff_addr   = a;
        store_data = sd;
        req_valid  = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'h0, 32'h1);
            req_valid = 1'b0;
            return;
        end
        r.data     = exp_data;
        r.err      = exp_err;
        r.chk_data = chk_data;
        r.cyc      = cyc + (exp_err ? 1 : 2 + waits);
        resp_q.push_back(r);
        if (!exp_err) begin
            b.addr  = {a[31:2], 2'b00};
            b.be    = exp_be;
            b.wd    = exp_wd;
            b.wr    = exp_wr;
            b.waits = waits;
            b.rdata = rdata;
            bus_q.push_back(b);
            exp_xfer++;
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || bus_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_resp_left", resp_q.size(), 32'h0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_read", {31'b0, avm_read}, 32'h0);
        chk("rst_write", {31'b0, avm_write}, 32'h0);
        chk("rst_address", avm_address, 32'h0);
        chk("rst_be", {28'b0, avm_byteenable}, 32'h0);
        chk("rst_wdata", avm_writedata, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_addr_error", {31'b0, addr_error}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        //     op     addr          store         w  rdata         exp data      chk err be       wdata         wr hold
        issue(6'h23, 32'h0000_1004, 32'h0,        0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 4'b1111, 32'h0,        0, 0); // lw
        issue(6'h20, 32'h0000_1003, 32'h0,        0, 32'h8012_3456, 32'hFFFF_FF80, 1, 0, 4'b1000, 32'h0,        0, 0); // lb
        issue(6'h24, 32'h0000_1003, 32'h0,        0, 32'h8012_3456, 32'h0000_0080, 1, 0, 4'b1000, 32'h0,        0, 0); // lbu
        issue(6'h29, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0,        32'h0,        0, 0, 4'b1100, 32'hABCD_ABCD, 1, 0); // sh
        issue(6'h23, 32'h0000_1002, 32'h0,        0, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        0, 0); // lw misaligned
        issue(6'h21, 32'h0000_1001, 32'h0,        0, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        0, 0); // lh misaligned
        issue(6'h08, 32'h0000_1000, 32'h0,        0, 32'h0,        32'h0,        1, 1, 4'b0000, 32'h0,        0, 0); // illegal opcode
        issue(6'h21, 32'h0000_1002, 32'h0,        0, 32'h8001_7FFF, 32'hFFFF_8001, 1, 0, 4'b1100, 32'h0,        0, 0); // lh upper
        issue(6'h25, 32'h0000_1000, 32'h0,        2, 32'h1234_8765, 32'h0000_8765, 1, 0, 4'b0011, 32'h0,        0, 0); // lhu lower
        issue(6'h28, 32'h0000_3001, 32'hAABB_CC5A, 0, 32'h0,        32'h0,        0, 0, 4'b0010, 32'h5A5A_5A5A, 1, 0); // sb
        issue(6'h2B, 32'h0000_3004, 32'hCAFE_F00D, 1, 32'h0,        32'h0,        0, 0, 4'b1111, 32'hCAFE_F00D, 1, 0); // sw
        issue(6'h20, 32'h0000_1001, 32'h0,        0, 32'h0000_7F00, 32'h0000_007F, 1, 0, 4'b0010, 32'h0,        0, 0); // lb positive
        drain();

        // Reset in the middle of a stalled read: strobe drops at once, no response follows.
        issue(6'h23, 32'h0000_0500, 32'h0,       20, 32'h5555_5555, 32'h5555_5555, 1, 0, 4'b1111, 32'h0,        0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_xfer -= bus_q.size();
        bus_q.delete();
        resp_q.delete();
        #1;
        chk("midrst_read", {31'b0, avm_read}, 32'h0);
        chk("midrst_write", {31'b0, avm_write}, 32'h0);
        chk("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_req_ready", {31'b0, req_ready}, 32'h1);
        issue(6'h23, 32'h0000_0040, 32'h0,        0, 32'h1122_3344, 32'h1122_3344, 1, 0, 4'b1111, 32'h0,        0, 0);
        drain();

        // Back-to-back with req_valid held: second request waits for req_ready.
        issue(6'h23, 32'h0000_0100, 32'h0,        1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 0, 4'b1111, 32'h0,        0, 1);
        issue(6'h2B, 32'h0000_0104, 32'h7654_3210, 0, 32'h0,        32'h0,        0, 0, 4'b1111, 32'h7654_3210, 1, 0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("bus_transfer_count", n_xfer, exp_xfer);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
